// File: rtl/sodor5_instr_pkg.sv
// Shared opcodes, LFSR taps, FSM states and field/encode helpers for the
// sodor5 constrained-random instruction source.
package sodor5_instr_pkg;

    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

    typedef enum logic [1:0] {
        WARMUP,
        RUN,
        DRAIN
    } state_t;

    // One Galois shift-right step.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        lfsr_next = (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'd0);
    endfunction

    // Turns the two LFSR states into one legal OP-IMM or BRANCH word.
    function automatic logic [31:0] encode_word(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        branch_en
    );
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [2:0]  f3b;
        logic        choice;
        imm    = a[11:0];
        rs1    = a[16:12];
        rs2    = a[21:17];
        rd     = a[26:22];
        f3     = a[29:27];
        f3b    = b[2:0];
        choice = b[3] | ~branch_en;
        // Shift immediates keep only the shamt (and the SRAI select bit).
        if (f3 == 3'd5) begin
            imm = imm & 12'h41F;
        end else if (f3 == 3'd1) begin
            imm = imm & 12'h01F;
        end
        if (!f3b[2]) begin
            f3b = f3b & 3'b001;
        end
        if (choice) begin
            encode_word = {imm, rs1, f3, rd, OPC_OPIMM};
        end else begin
            encode_word = {imm[11], imm[9:4], rs2, rs1, f3b, imm[3:1], 1'b0,
                           imm[10], OPC_BRANCH};
        end
    endfunction

endpackage

// File: rtl/sodor5_lfsr32.sv
// 32-bit Galois LFSR that advances only when step is high; a zero seed is
// replaced by 1 so the register never locks up.
module sodor5_lfsr32
    import sodor5_instr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] state
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= (seed == 32'd0) ? 32'd1 : seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/sodor5_rand_instr_src.sv
// Deterministic constrained-random RV32I instruction source on a valid/ready
// port: warm-up NOPs, then random OP-IMM/BRANCH words, then NOPs forever.
module sodor5_rand_instr_src
    import sodor5_instr_pkg::*;
#(
    parameter logic [31:0] SEED_A      = 32'h0001_17E4,
    parameter logic [31:0] SEED_B      = 32'h8BAD_F00D,
    parameter int unsigned WARMUP_NOPS = 4,
    parameter int unsigned MAX_INSTRS  = 0,
    parameter bit          BRANCH_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        done,
    output logic [31:0] count
);

    // Handshake: a word transfers on any posedge where instr_valid && instr_ready.
    // instr is held stable while instr_valid && !instr_ready.
    state_t      state;
    logic [31:0] warm_cnt;
    logic [31:0] lfsr_a;
    logic [31:0] lfsr_b;
    logic [31:0] next_a;
    logic [31:0] next_b;
    logic [31:0] word_now;
    logic [31:0] word_next;
    logic        hs;
    logic        step;

    assign hs   = instr_valid && instr_ready;
    assign step = hs && (state == RUN);

    sodor5_lfsr32 u_lfsr_a (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED_A),
        .step  (step),
        .state (lfsr_a)
    );

    sodor5_lfsr32 u_lfsr_b (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED_B),
        .step  (step),
        .state (lfsr_b)
    );

    // The word after an accepted one comes from the LFSR states they step to.
    always_comb begin
        next_a    = lfsr_next(lfsr_a);
        next_b    = lfsr_next(lfsr_b);
        word_now  = encode_word(lfsr_a, lfsr_b, BRANCH_EN);
        word_next = encode_word(next_a, next_b, BRANCH_EN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WARMUP;
            warm_cnt    <= 32'd0;
            instr       <= INSTR_NOP;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            count       <= 32'd0;
        end else begin
            instr_valid <= 1'b1;
            case (state)
                WARMUP: begin
                    if (WARMUP_NOPS == 0) begin
                        state <= RUN;
                        instr <= word_now;
                    end else if (hs) begin
                        warm_cnt <= warm_cnt + 32'd1;
                        if (warm_cnt == WARMUP_NOPS - 1) begin
                            state <= RUN;
                            instr <= word_now;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (count != 32'hFFFF_FFFF) begin
                            count <= count + 32'd1;
                        end
                        if ((MAX_INSTRS != 0) && (count + 32'd1 == MAX_INSTRS)) begin
                            state <= DRAIN;
                            instr <= INSTR_NOP;
                            done  <= 1'b1;
                        end else begin
                            instr <= word_next;
                        end
                    end
                end
                DRAIN: begin
                    instr <= INSTR_NOP;
                    done  <= 1'b1;
                end
                default: begin
                    state <= WARMUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sodor5_rand_instr_src.sv
// Bench for sodor5_rand_instr_src: three instances (default, MAX_INSTRS=3,
// BRANCH_EN=0 with no warm-up) checked against a field-level stream model.
module tb_sodor5_rand_instr_src;

    localparam int          N_MODEL = 10200;
    localparam int          N_NB    = 300;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] SA      = 32'h0001_17E4;
    localparam logic [31:0] SB      = 32'h8BAD_F00D;

    logic        clk = 1'b0;
    logic        reset_i [3];
    logic        ready_i [3];
    logic [31:0] instr_o [3];
    logic        valid_o [3];
    logic        done_o  [3];
    logic [31:0] count_o [3];

    int          checks   = 0;
    int          failures = 0;
    int          idx      = 0;
    logic [31:0] model_be [N_MODEL];
    logic [31:0] model_nb [N_NB];

    always #5 clk = ~clk;

    sodor5_rand_instr_src #(.WARMUP_NOPS(4), .MAX_INSTRS(0), .BRANCH_EN(1'b1)) dut (
        .clk(clk), .reset(reset_i[0]), .instr(instr_o[0]), .instr_valid(valid_o[0]),
        .instr_ready(ready_i[0]), .done(done_o[0]), .count(count_o[0])
    );

    sodor5_rand_instr_src #(.WARMUP_NOPS(4), .MAX_INSTRS(3), .BRANCH_EN(1'b1)) dut_max (
        .clk(clk), .reset(reset_i[1]), .instr(instr_o[1]), .instr_valid(valid_o[1]),
        .instr_ready(ready_i[1]), .done(done_o[1]), .count(count_o[1])
    );

    sodor5_rand_instr_src #(.WARMUP_NOPS(0), .MAX_INSTRS(0), .BRANCH_EN(1'b0)) dut_nb (
        .clk(clk), .reset(reset_i[2]), .instr(instr_o[2]), .instr_valid(valid_o[2]),
        .instr_ready(ready_i[2]), .done(done_o[2]), .count(count_o[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return (s & 32'd1) != 0 ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b,
                                             input bit branch_en);
        int unsigned imm, rs1, rs2, rd, f3, f3b, w;
        imm = a & 32'hFFF;
        rs1 = (a >> 12) & 31;
        rs2 = (a >> 17) & 31;
        rd  = (a >> 22) & 31;
        f3  = (a >> 27) & 7;
        f3b = b & 7;
        if (f3 == 5) imm = imm & 32'h41F;
        else if (f3 == 1) imm = imm & 32'h1F;
        if (f3b < 4) f3b = f3b & 1;
        if (((b >> 3) & 1) == 1 || !branch_en) begin
            w = (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        end else begin
            w = (((imm >> 11) & 1) << 31) | (((imm >> 4) & 63) << 25) | (rs2 << 20)
              | (rs1 << 15) | (f3b << 12) | (((imm >> 1) & 7) << 9)
              | (((imm >> 10) & 1) << 7) | 32'h63;
        end
        return w;
    endfunction

    function automatic bit legal_word(input logic [31:0] w);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] hi;
        opc = w[6:0];
        f3  = w[14:12];
        hi  = w[31:25];
        if (opc == 7'b0010011) begin
            if (f3 == 3'd1) return hi == 7'h00;
            if (f3 == 3'd5) return (hi == 7'h00) || (hi == 7'h20);
            return 1'b1;
        end
        if (opc == 7'b1100011) return (f3 != 3'd2) && (f3 != 3'd3) && (w[8] == 1'b0);
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset(input int d, input int cycles);
        @(negedge clk);
        reset_i[d] = 1'b1;
        ready_i[d] = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_i[d] = 1'b0;
    endtask

    task automatic accept_word(input int d, output logic [31:0] w);
        int n;
        n = 0;
        w = 32'hx;
        @(negedge clk);
        while (!valid_o[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!valid_o[d]) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout dut=%0d valid=%b required=1", d, valid_o[d]);
        end else begin
            w = instr_o[d];
            ready_i[d] = 1'b1;
            @(posedge clk);
            #1;
            ready_i[d] = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        reset_i[0] = 1'b1;
        ready_i[0] = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (instr_o[0] !== NOP || valid_o[0] !== 1'b0 || count_o[0] !== 32'd0 || done_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_state instr=%h valid=%b count=%0d done=%b required instr=%h valid=0 count=0 done=0",
                     instr_o[0], valid_o[0], count_o[0], done_o[0], NOP);
        end
        ready_i[0] = 1'b0;
        reset_i[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o[0] !== 1'b1 || instr_o[0] !== NOP) begin
            failures++;
            $display("FAIL valid_after_release valid=%b instr=%h required valid=1 instr=%h",
                     valid_o[0], instr_o[0], NOP);
        end
    endtask

    task automatic test_warmup();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            accept_word(0, w);
            checks++;
            if (w !== NOP) begin
                failures++;
                $display("FAIL warmup_nop_%0d got=%h required=%h", i, w, NOP);
            end
        end
        checks++;
        if (count_o[0] !== 32'd0) begin
            failures++;
            $display("FAIL warmup_count got=%0d required=0", count_o[0]);
        end
        accept_word(0, w);
        checks++;
        if (w !== model_be[0] || (w[6:0] !== 7'b0010011 && w[6:0] !== 7'b1100011)) begin
            failures++;
            $display("FAIL first_random got=%h required=%h", w, model_be[0]);
        end
        idx = 1;
    endtask

    task automatic test_stall();
        logic [31:0] w;
        @(negedge clk);
        checks++;
        if (instr_o[0] !== model_be[idx] || count_o[0] !== 32'(idx)) begin
            failures++;
            $display("FAIL stall_start instr=%h count=%0d required instr=%h count=%0d",
                     instr_o[0], count_o[0], model_be[idx], idx);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (instr_o[0] !== model_be[idx] || count_o[0] !== 32'(idx)) begin
                failures++;
                $display("FAIL stall_hold instr=%h count=%0d required instr=%h count=%0d",
                         instr_o[0], count_o[0], model_be[idx], idx);
            end
        end
        accept_word(0, w);
        checks++;
        if (w !== model_be[idx]) begin
            failures++;
            $display("FAIL stall_release_word got=%h required=%h", w, model_be[idx]);
        end
        idx++;
        checks++;
        if (count_o[0] !== 32'(idx) || instr_o[0] !== model_be[idx]) begin
            failures++;
            $display("FAIL stall_release_next count=%0d instr=%h required count=%0d instr=%h",
                     count_o[0], instr_o[0], idx, model_be[idx]);
        end
    endtask

    task automatic test_stream();
        logic [31:0] w;
        int n_branch;
        int n_itype;
        n_branch = 0;
        n_itype  = 0;
        for (int k = 0; k < 10000; k++) begin
            // Occasional random back-pressure bubble between words.
            if ($urandom_range(0, 7) == 0) @(negedge clk);
            accept_word(0, w);
            checks++;
            if (w !== model_be[idx]) begin
                failures++;
                $display("FAIL stream_word_%0d got=%h required=%h", idx, w, model_be[idx]);
            end
            checks++;
            if (!legal_word(w)) begin
                failures++;
                $display("FAIL stream_legal_%0d got=%h required=legal OP-IMM/BRANCH", idx, w);
            end
            if (w[6:0] == 7'b1100011) n_branch++;
            else n_itype++;
            idx++;
        end
        checks++;
        if (count_o[0] !== 32'(idx) || n_branch == 0 || n_itype == 0) begin
            failures++;
            $display("FAIL stream_summary count=%0d branches=%0d itypes=%0d required count=%0d both>0",
                     count_o[0], n_branch, n_itype, idx);
        end
    endtask

    task automatic test_replay_reset();
        logic [31:0] w;
        int bad_nops;
        // Reset and a handshake in the same cycle: reset must win.
        @(negedge clk);
        reset_i[0] = 1'b1;
        ready_i[0] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (valid_o[0] !== 1'b0 || count_o[0] !== 32'd0 || instr_o[0] !== NOP) begin
            failures++;
            $display("FAIL reset_wins valid=%b count=%0d instr=%h required valid=0 count=0 instr=%h",
                     valid_o[0], count_o[0], instr_o[0], NOP);
        end
        ready_i[0] = 1'b0;
        @(negedge clk);
        reset_i[0] = 1'b0;
        bad_nops = 0;
        for (int i = 0; i < 4; i++) begin
            accept_word(0, w);
            if (w !== NOP) bad_nops++;
        end
        checks++;
        if (bad_nops != 0) begin
            failures++;
            $display("FAIL replay_warmup non_nop_words=%0d required=0", bad_nops);
        end
        for (int k = 0; k < 50; k++) begin
            accept_word(0, w);
            checks++;
            if (w !== model_be[k]) begin
                failures++;
                $display("FAIL replay_word_%0d got=%h required=%h", k, w, model_be[k]);
            end
        end
    endtask

    task automatic test_max_instrs();
        logic [31:0] w;
        apply_reset(1, 2);
        for (int i = 0; i < 4; i++) begin
            accept_word(1, w);
            checks++;
            if (w !== NOP) begin
                failures++;
                $display("FAIL max_warmup_%0d got=%h required=%h", i, w, NOP);
            end
        end
        for (int k = 0; k < 3; k++) begin
            accept_word(1, w);
            checks++;
            if (w !== model_be[k]) begin
                failures++;
                $display("FAIL max_word_%0d got=%h required=%h", k, w, model_be[k]);
            end
            if (k == 1) begin
                checks++;
                if (done_o[1] !== 1'b0 || count_o[1] !== 32'd2) begin
                    failures++;
                    $display("FAIL max_before_done done=%b count=%0d required done=0 count=2",
                             done_o[1], count_o[1]);
                end
            end
        end
        checks++;
        if (done_o[1] !== 1'b1 || count_o[1] !== 32'd3 || instr_o[1] !== NOP) begin
            failures++;
            $display("FAIL max_done done=%b count=%0d instr=%h required done=1 count=3 instr=%h",
                     done_o[1], count_o[1], instr_o[1], NOP);
        end
        for (int i = 0; i < 3; i++) begin
            accept_word(1, w);
            checks++;
            if (w !== NOP || count_o[1] !== 32'd3 || done_o[1] !== 1'b1) begin
                failures++;
                $display("FAIL drain_%0d word=%h count=%0d done=%b required word=%h count=3 done=1",
                         i, w, count_o[1], done_o[1], NOP);
            end
        end
    endtask

    task automatic test_no_branch();
        logic [31:0] w;
        apply_reset(2, 2);
        for (int k = 0; k < N_NB; k++) begin
            accept_word(2, w);
            checks++;
            if (w !== model_nb[k] || w[6:0] === 7'b1100011) begin
                failures++;
                $display("FAIL nobranch_word_%0d got=%h required=%h", k, w, model_nb[k]);
            end
        end
        checks++;
        if (count_o[2] !== 32'(N_NB)) begin
            failures++;
            $display("FAIL nobranch_count got=%0d required=%0d", count_o[2], N_NB);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        for (int d = 0; d < 3; d++) begin
            reset_i[d] = 1'b1;
            ready_i[d] = 1'b0;
        end
        a = SA;
        b = SB;
        for (int k = 0; k < N_MODEL; k++) begin
            model_be[k] = ref_word(a, b, 1'b1);
            if (k < N_NB) model_nb[k] = ref_word(a, b, 1'b0);
            a = ref_step(a);
            b = ref_step(b);
        end

        test_reset();
        test_warmup();
        test_stall();
        test_stream();
        test_replay_reset();
        test_max_instrs();
        test_no_branch();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
